i2c_target: RTL and testbench



---
 rtl/i2c_target.sv | 217 +++++++++++++++++++++
 tb/tb_i2c_target.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target responder: oversamples SCL/SDA, matches a 7-bit address, streams
// write bytes out on rx_* and fetches read bytes over tx_*; SDA is pull-low only.
`timescale 1ns/1ps
module i2c_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       addr_match
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_DATA,
    RX_ACK,
    TX_DATA,
    TX_ACK,
    WAIT_STOP
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_lvl;
  logic                   sda_lvl;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   sda_rise;
  logic                   sda_fall;
  logic                   start_det;
  logic                   stop_det;
  logic [2:0]             bit_cnt;
  logic [6:0]             shift;
  logic [6:0]             tx_shift;
  logic                   rw;
  logic                   ack;
  logic                   phase;

  // Synchronizers, edge-detect level registers and registered edge strobes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_sync <= {SYNC_STAGES{1'b1}};
      sda_sync <= {SYNC_STAGES{1'b1}};
      scl_lvl  <= 1'b1;
      sda_lvl  <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      sda_rise <= 1'b0;
      sda_fall <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_lvl  <= scl_sync[SYNC_STAGES-1];
      sda_lvl  <= sda_sync[SYNC_STAGES-1];
      scl_rise <= scl_sync[SYNC_STAGES-1] & ~scl_lvl;
      scl_fall <= ~scl_sync[SYNC_STAGES-1] & scl_lvl;
      sda_rise <= sda_sync[SYNC_STAGES-1] & ~sda_lvl;
      sda_fall <= ~sda_sync[SYNC_STAGES-1] & sda_lvl;
    end
  end

  // An SDA edge only counts as START/STOP when SCL was steadily high (no SCL edge alongside).
  assign start_det = sda_fall & scl_lvl & ~scl_rise & ~scl_fall;
  assign stop_det  = sda_rise & scl_lvl & ~scl_rise & ~scl_fall;

  // Protocol FSM; ACK windows use 'phase' to span exactly one SCL low-to-low period.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shift      <= 7'd0;
      tx_shift   <= 7'd0;
      rw         <= 1'b0;
      ack        <= 1'b0;
      phase      <= 1'b0;
      sda_oe     <= 1'b0;
      rx_data    <= 8'd0;
      rx_valid   <= 1'b0;
      tx_req     <= 1'b0;
      busy       <= 1'b0;
      addr_match <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (start_det) begin
        state      <= ADDR;
        bit_cnt    <= 3'd0;
        shift      <= 7'd0;
        phase      <= 1'b0;
        sda_oe     <= 1'b0;
        addr_match <= 1'b0;
      end else if (stop_det) begin
        state      <= IDLE;
        phase      <= 1'b0;
        sda_oe     <= 1'b0;
        busy       <= 1'b0;
        addr_match <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sda_oe <= 1'b0;
          end
          ADDR: begin
            if (scl_rise) begin
              shift   <= {shift[5:0], sda_lvl};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                // General call (0x00) is never acknowledged.
                if ((shift == DEV_ADDR) && (shift != 7'h00)) begin
                  state <= ADDR_ACK;
                  rw    <= sda_lvl;
                  busy  <= 1'b1;
                end else begin
                  state <= WAIT_STOP;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                phase      <= 1'b1;
                sda_oe     <= 1'b1;
                addr_match <= 1'b1;
              end else begin
                phase <= 1'b0;
                if (rw) begin
                  state    <= TX_DATA;
                  tx_req   <= 1'b1;
                  tx_shift <= tx_data[6:0];
                  sda_oe   <= ~tx_data[7];
                  bit_cnt  <= 3'd1;
                end else begin
                  state  <= RX_DATA;
                  sda_oe <= 1'b0;
                end
              end
            end
          end
          RX_DATA: begin
            if (scl_rise) begin
              shift   <= {shift[5:0], sda_lvl};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data  <= {shift, sda_lvl};
                rx_valid <= 1'b1;
                ack      <= rx_ready;
                state    <= RX_ACK;
              end
            end
          end
          RX_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                phase  <= 1'b1;
                sda_oe <= ack;
              end else begin
                phase  <= 1'b0;
                sda_oe <= 1'b0;
                state  <= ack ? RX_DATA : WAIT_STOP;
              end
            end
          end
          TX_DATA: begin
            // bit_cnt counts bits already presented; wrapping to 0 means the byte is out.
            if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sda_oe <= 1'b0;
                state  <= TX_ACK;
              end else begin
                sda_oe   <= ~tx_shift[6];
                tx_shift <= {tx_shift[5:0], 1'b0};
                bit_cnt  <= bit_cnt + 3'd1;
              end
            end
          end
          TX_ACK: begin
            if (scl_rise) begin
              if (sda_lvl) begin
                state <= WAIT_STOP;
              end else begin
                phase <= 1'b1;
              end
            end else if (scl_fall && phase) begin
              phase    <= 1'b0;
              state    <= TX_DATA;
              tx_req   <= 1'b1;
              tx_shift <= tx_data[6:0];
              sda_oe   <= ~tx_data[7];
              bit_cnt  <= 3'd1;
            end
          end
          WAIT_STOP: begin
            sda_oe <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: behavioural bus master on a wired-AND SDA, with
// scoreboards for received write bytes and transmitted read bytes.
`timescale 1ns/1ps
module tb_i2c_target;

  localparam int T = 50;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       scl      = 1'b1;
  logic       msda     = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       busy;
  logic       addr_match;
  wire        sda_bus = msda & ~sda_oe;

  int errors = 0;
  int checks = 0;
  int rx_cnt = 0;
  int tx_req_cnt = 0;
  int oe_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  always #5 clk = ~clk;

  i2c_target #(.DEV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .scl_i(scl), .sda_i(sda_bus),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_req(tx_req), .busy(busy), .addr_match(addr_match)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Receive scoreboard and SDA pull-low activity counter.
  always @(negedge clk) begin
    if (reset_n && rx_valid) begin
      rx_cnt++;
      check("rx_expected", (rx_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (rx_q.size() != 0) check("rx_data", {24'h0, rx_data}, {24'h0, rx_q.pop_front()});
    end
    if (sda_oe) oe_cnt++;
  end

  // Read-byte source: presents the queue head, advances on each tx_req.
  always @(negedge clk) begin
    if (reset_n && tx_req) begin
      tx_req_cnt++;
      if (tx_q.size() != 0) void'(tx_q.pop_front());
    end
    tx_data = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
  end

  task automatic bit_io(input logic b, output logic s);
    #T msda = b;
    #T scl = 1'b1;
    #T s = sda_bus;
    #T scl = 1'b0;
  endtask

  task automatic i2c_start();
    #T msda = 1'b1;
    #T scl = 1'b1;
    #T msda = 1'b0;
    #T scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #T msda = 1'b0;
    #T scl = 1'b1;
    #T msda = 1'b1;
    #(2*T);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(b[i], s);
    bit_io(1'b1, s);
    acked = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      b[i] = s;
    end
    bit_io(~mack, s);
  endtask

  initial begin
    logic       a;
    logic       s;
    logic [7:0] b;
    int         snap_oe, snap_rx, snap_tx;

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_req", tx_req, 0);
    check("rst_busy", busy, 0);
    check("rst_addr_match", addr_match, 0);
    check("rst_rx_data", rx_data, 0);
    reset_n = 1'b1;
    #(4*T);

    // Write of two bytes, all acknowledged.
    rx_q.push_back(8'h3C);
    rx_q.push_back(8'hC3);
    snap_rx = rx_cnt;
    i2c_start();
    write_byte(8'hA0, a); check("t1_addr_ack", a, 1);
    check("t1_busy", busy, 1);
    check("t1_addr_match", addr_match, 1);
    write_byte(8'h3C, a); check("t1_d0_ack", a, 1);
    write_byte(8'hC3, a); check("t1_d1_ack", a, 1);
    i2c_stop();
    check("t1_busy_after_stop", busy, 0);
    check("t1_match_after_stop", addr_match, 0);
    check("t1_rx_count", rx_cnt - snap_rx, 2);

    // Foreign address: nothing driven, nothing received.
    snap_oe = oe_cnt;
    snap_rx = rx_cnt;
    i2c_start();
    write_byte(8'hA2, a); check("t2_addr_nack", a, 0);
    check("t2_addr_match", addr_match, 0);
    write_byte(8'hFF, a); check("t2_data_nack", a, 0);
    i2c_stop();
    check("t2_oe_quiet", oe_cnt - snap_oe, 0);
    check("t2_rx_count", rx_cnt - snap_rx, 0);
    check("t2_busy", busy, 0);

    // Read of two bytes, master ACKs then NACKs.
    tx_q.push_back(8'h96);
    tx_q.push_back(8'h5A);
    @(negedge clk);
    snap_tx = tx_req_cnt;
    i2c_start();
    write_byte(8'hA1, a); check("t3_addr_ack", a, 1);
    read_byte(1'b1, b); check("t3_rd0", b, 8'h96);
    read_byte(1'b0, b); check("t3_rd1", b, 8'h5A);
    snap_oe = oe_cnt;
    for (int i = 0; i < 2; i++) bit_io(1'b1, s);
    check("t3_oe_after_nack", oe_cnt - snap_oe, 0);
    check("t3_sda_oe", sda_oe, 0);
    i2c_stop();
    check("t3_tx_req_count", tx_req_cnt - snap_tx, 2);

    // rx_ready low NACKs the second data byte; the third is ignored.
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h22);
    snap_rx = rx_cnt;
    i2c_start();
    write_byte(8'hA0, a); check("t4_addr_ack", a, 1);
    rx_ready = 1'b1;
    write_byte(8'h11, a); check("t4_d0_ack", a, 1);
    rx_ready = 1'b0;
    write_byte(8'h22, a); check("t4_d1_nack", a, 0);
    rx_ready = 1'b1;
    write_byte(8'h33, a); check("t4_d2_ignored", a, 0);
    i2c_stop();
    check("t4_rx_count", rx_cnt - snap_rx, 2);

    // Repeated START after a partial write byte, then a read.
    tx_q.push_back(8'hC5);
    @(negedge clk);
    snap_rx = rx_cnt;
    snap_tx = tx_req_cnt;
    i2c_start();
    write_byte(8'hA0, a); check("t5_addr_ack", a, 1);
    bit_io(1'b1, s);
    bit_io(1'b0, s);
    bit_io(1'b1, s);
    i2c_start();
    check("t5_match_cleared", addr_match, 0);
    write_byte(8'hA1, a); check("t5_raddr_ack", a, 1);
    read_byte(1'b0, b); check("t5_rd", b, 8'hC5);
    i2c_stop();
    check("t5_rx_count", rx_cnt - snap_rx, 0);
    check("t5_tx_req_count", tx_req_cnt - snap_tx, 1);

    // Reset while the target is pulling SDA low for a 0 data bit.
    tx_q.push_back(8'h00);
    @(negedge clk);
    i2c_start();
    write_byte(8'hA1, a); check("t6_addr_ack", a, 1);
    #T; #T scl = 1'b1; #T;
    check("t6_oe_before_reset", sda_oe, 1);
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk);
    check("t6_oe_reset", sda_oe, 0);
    check("t6_busy_reset", busy, 0);
    check("t6_match_reset", addr_match, 0);
    check("t6_txreq_reset", tx_req, 0);
    check("t6_rxvalid_reset", rx_valid, 0);
    reset_n = 1'b1;
    #T scl = 1'b0;
    i2c_stop();
    i2c_start();
    write_byte(8'hA0, a); check("t6_post_reset_ack", a, 1);
    i2c_stop();

    check("rx_queue_drained", rx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
